// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions: funct3 encodings for loads/stores and the data-memory
// responder's request record, state encoding and latency counter width.
package riscv_cpu_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   localparam int DMEM_LAT_WIDTH = 3;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_WAIT,
      DMEM_RESP
   } dmem_state_e;

endpackage

// File: rtl/riscv_dmem_align.sv
// Byte-lane steering for the data memory: store byte-enables and lane-replicated
// write data on the request side, sign/zero extension of load data on the response side.
module riscv_dmem_align
   import riscv_cpu_pkg::*;
(
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lane,
   output logic        misaligned,
   output logic        illegal_op,
   input  logic [2:0]  rsp_funct3,
   input  logic [1:0]  rsp_addr_lo,
   input  logic [31:0] raw_word,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   // funct3[1:0] encodes size (00 byte, 01 half, 10 word) for both loads and stores.
   always_comb begin
      byte_en    = 4'b0000;
      wdata_lane = req_wdata;
      misaligned = 1'b0;
      case (req_funct3[1:0])
         2'b00: begin
            byte_en    = 4'b0001 << req_addr_lo;
            wdata_lane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            byte_en    = 4'b0011 << {req_addr_lo[1], 1'b0};
            wdata_lane = {2{req_wdata[15:0]}};
            misaligned = req_addr_lo[0];
         end
         2'b10: begin
            byte_en    = 4'b1111;
            misaligned = (req_addr_lo != 2'b00);
         end
         default: ;
      endcase
      if (req_we) begin
         illegal_op = (req_funct3 > FUNCT3_SW);
      end else begin
         illegal_op = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
      end
   end

   assign shifted = raw_word >> {rsp_addr_lo, 3'b000};

   always_comb begin
      rdata_ext = '0;
      case (rsp_funct3)
         FUNCT3_LB:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         FUNCT3_LH:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         FUNCT3_LW:  rdata_ext = raw_word;
         FUNCT3_LBU: rdata_ext = {24'h0, shifted[7:0]};
         FUNCT3_LHU: rdata_ext = {16'h0, shifted[15:0]};
         default:    rdata_ext = '0;
      endcase
   end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for MEM-stage data requests: one outstanding access at a time,
// stores commit at the grant edge, and the response arrives LATENCY+1 cycles after the grant.
module riscv_dmem_responder
   import riscv_cpu_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] BYTE_SPAN = 33'(DEPTH_WORDS) << 2;
   localparam logic [DMEM_LAT_WIDTH-1:0] LAT_LAST = DMEM_LAT_WIDTH'(LATENCY - 1);

   dmem_state_e               state_q, state_d;
   logic [DMEM_LAT_WIDTH-1:0] cnt_q;
   dmem_req_t                 req_q;
   logic                      err_q;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [31:0]      req_off, rsp_off;
   logic [IDX_W-1:0] req_idx, rsp_idx;
   logic [3:0]       byte_en;
   logic [31:0]      wdata_lane, rdata_ext;
   logic             misaligned, illegal_op, range_err, req_err, mem_we;
   logic             unused_bits;

   riscv_dmem_align u_align (
      .req_we      (we_i),
      .req_funct3  (funct3_i),
      .req_addr_lo (addr_i[1:0]),
      .req_wdata   (wdata_i),
      .byte_en     (byte_en),
      .wdata_lane  (wdata_lane),
      .misaligned  (misaligned),
      .illegal_op  (illegal_op),
      .rsp_funct3  (req_q.funct3),
      .rsp_addr_lo (req_q.addr[1:0]),
      .raw_word    (mem[rsp_idx]),
      .rdata_ext   (rdata_ext)
   );

   // Addresses below BASE_ADDR wrap to huge offsets and so land in the range error.
   assign req_off   = addr_i - BASE_ADDR;
   assign range_err = {1'b0, req_off} >= BYTE_SPAN;
   assign req_err   = misaligned | illegal_op | range_err;
   assign req_idx   = req_off[IDX_W+1:2];

   assign gnt_o  = req_i & (state_q == DMEM_IDLE);
   assign mem_we = gnt_o & we_i & ~req_err & rst_ni;

   assign rsp_off     = req_q.addr - BASE_ADDR;
   assign rsp_idx     = rsp_off[IDX_W+1:2];
   assign unused_bits = ^{rsp_off[31:IDX_W+2], req_q.wdata};

   assign rvalid_o = (state_q == DMEM_RESP);
   assign err_o    = rvalid_o & err_q;
   assign rdata_o  = (rvalid_o & ~err_q & ~req_q.we) ? rdata_ext : '0;

   // Write port is gated by rst_ni so a request presented during reset never lands.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[req_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (gnt_o) begin
            cnt_q <= '0;
            req_q <= '{we: we_i, funct3: funct3_i, addr: addr_i, wdata: wdata_i};
            err_q <= req_err;
         end else if (state_q == DMEM_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DMEM_IDLE: if (req_i) state_d = (LATENCY == 0) ? DMEM_RESP : DMEM_WAIT;
         DMEM_WAIT: if (cnt_q == LAT_LAST) state_d = DMEM_RESP;
         DMEM_RESP: state_d = DMEM_IDLE;
         default:   state_d = DMEM_IDLE;
      endcase
   end

endmodule
